// File: rtl/parallel_to_serial_if.sv
// Parallel-to-serial port bundle.
// Producer word handshake plus serial stream and status.
interface parallel_to_serial_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             word_start;
  logic             busy;
  logic [7:0]       word_count;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  bit_valid,
    input  word_start,
    input  busy,
    input  word_count
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output bit_valid,
    output word_start,
    output busy,
    output word_count
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Word serializer: one-word holding buffer feeding a shifter.
// Back-to-back words stream gap-free; words are counted mod 256.
module parallel_to_serial #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  parallel_to_serial_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_q, serial_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_start_q, word_start_d;
  logic [7:0]       word_count_q, word_count_d;
  logic             accept;
  logic             last_bit;
  logic             load;

  assign accept   = bus.data_valid & ready_q;
  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign load     = hold_full_q && ((state_q == IDLE) || last_bit);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: stay in SHIFT while words keep arriving
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (hold_full_q) state_d = SHIFT;
      SHIFT: if (last_bit && !hold_full_q) state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    serial_d     = serial_q;
    bit_valid_d  = bit_valid_q;
    word_start_d = 1'b0;
    word_count_d = word_count_q;
    if (load) hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end
    if (last_bit) word_count_d = word_count_q + 8'd1;
    if (load) begin
      cnt_d        = '0;
      bit_valid_d  = 1'b1;
      word_start_d = 1'b1;
      if (MSB_FIRST) begin
        serial_d = hold_q[WIDTH-1];
        shreg_d  = hold_q << 1;
      end else begin
        serial_d = hold_q[0];
        shreg_d  = hold_q >> 1;
      end
    end else if (last_bit) begin
      bit_valid_d = 1'b0;
      serial_d    = 1'b0;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + CW'(1);
      if (MSB_FIRST) begin
        serial_d = shreg_q[WIDTH-1];
        shreg_d  = shreg_q << 1;
      end else begin
        serial_d = shreg_q[0];
        shreg_d  = shreg_q >> 1;
      end
    end
    ready_d = !hold_full_d;
  end

  // Datapath registers; ready comes up set out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      serial_q     <= 1'b0;
      bit_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
      word_count_q <= 8'd0;
      ready_q      <= 1'b1;
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      serial_q     <= serial_d;
      bit_valid_q  <= bit_valid_d;
      word_start_q <= word_start_d;
      word_count_q <= word_count_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.data_ready = ready_q;
  assign bus.serial_out = serial_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.word_start = word_start_q;
  assign bus.word_count = word_count_q;
  assign bus.busy       = hold_full_q | (state_q == SHIFT);
endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: LSB-first and MSB-first instances
// driven together, checked against a word-timeline reference model.
module tb_parallel_to_serial;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         dv;
  logic [W-1:0] din;

  always #5 clk = ~clk;

  parallel_to_serial_if #(.WIDTH(W)) bus_l ();
  parallel_to_serial_if #(.WIDTH(W)) bus_m ();

  assign bus_l.data_in    = din;
  assign bus_l.data_valid = dv;
  assign bus_m.data_in    = din;
  assign bus_m.data_valid = dv;

  parallel_to_serial #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  parallel_to_serial #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each accepted word k has accept edge a_k and
  // start edge s_k = max(a_k+1, s_{k-1}+W); bits occupy s_k..s_k+W-1.
  int           cyc = 0;
  int           q_a[$];
  int           q_s[$];
  logic [W-1:0] q_w[$];
  int           last_s = -1000;
  int           completed = 0;
  bit           last_acc;

  logic [31:0]  obs_l, obs_m, ws_l;
  int           obs_n, runs_l;
  bit           prev_bv;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hold_full_at(int e);
    for (int k = 0; k < q_a.size(); k++)
      if (q_a[k] <= e && e < q_s[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q_a.delete();
    q_s.delete();
    q_w.delete();
    last_s    = -1000;
    completed = 0;
  endtask

  task automatic clr_obs();
    obs_l   = '0;
    obs_m   = '0;
    ws_l    = '0;
    obs_n   = 0;
    runs_l  = 0;
    prev_bv = 1'b0;
  endtask

  task automatic check_outputs();
    bit hf, bv, ws, bl, bm;
    int e;
    e = cyc;
    while (q_s.size() > 0 && q_s[0] + W <= e) begin
      void'(q_a.pop_front());
      void'(q_s.pop_front());
      void'(q_w.pop_front());
      completed = (completed + 1) % 256;
    end
    hf = hold_full_at(e);
    bv = 1'b0; ws = 1'b0; bl = 1'b0; bm = 1'b0;
    for (int k = 0; k < q_s.size(); k++) begin
      if (q_s[k] <= e && e < q_s[k] + W) begin
        bv = 1'b1;
        ws = (e == q_s[k]);
        bl = q_w[k][e - q_s[k]];
        bm = q_w[k][W - 1 - (e - q_s[k])];
      end
    end
    chk("ready_l",  bus_l.data_ready, !hf);
    chk("ready_m",  bus_m.data_ready, !hf);
    chk("bv_l",     bus_l.bit_valid,  bv);
    chk("bv_m",     bus_m.bit_valid,  bv);
    chk("ws_l",     bus_l.word_start, ws);
    chk("ws_m",     bus_m.word_start, ws);
    chk("ser_l",    bus_l.serial_out, bl);
    chk("ser_m",    bus_m.serial_out, bm);
    chk("busy_l",   bus_l.busy,       hf | bv);
    chk("busy_m",   bus_m.busy,       hf | bv);
    chk("wcnt_l",   bus_l.word_count, completed);
    chk("wcnt_m",   bus_m.word_count, completed);
    if (bus_l.bit_valid === 1'b1) begin
      obs_l = {obs_l[30:0], bus_l.serial_out};
      obs_m = {obs_m[30:0], bus_m.serial_out};
      ws_l  = {ws_l[30:0], bus_l.word_start};
      obs_n++;
      if (!prev_bv) runs_l++;
    end
    prev_bv = (bus_l.bit_valid === 1'b1);
  endtask

  task automatic tick();
    bit acc;
    acc = dv && !rst && !hold_full_at(cyc);
    @(posedge clk);
    cyc++;
    #1;
    last_acc = acc;
    if (acc) begin
      q_a.push_back(cyc);
      last_s = (cyc + 1 > last_s + W) ? cyc + 1 : last_s + W;
      q_s.push_back(last_s);
      q_w.push_back(din);
    end
    check_outputs();
  endtask

  task automatic send_word(logic [W-1:0] w);
    bit done;
    done = 1'b0;
    din  = w;
    dv   = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = last_acc;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q_s.size() > 0; i++) tick();
    if (q_s.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ser",  bus_l.serial_out, 1'b0);
    chk("rst_bv",   bus_l.bit_valid,  1'b0);
    chk("rst_ws",   bus_l.word_start, 1'b0);
    chk("rst_busy", bus_l.busy,       1'b0);
    chk("rst_wcnt", bus_l.word_count, 8'd0);
    chk("rst_bv_m", bus_m.bit_valid,  1'b0);
    model_clear();
    tick();
    #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    dv  = 1'b1;
    din = 4'hF;
    clr_obs();
    #1;
    check_outputs();
    tick();
    tick();
    dv  = 1'b0;
    rst = 1'b0;

    clr_obs();
    send_word(4'b1011);
    dv = 1'b0;
    drain();
    chk("w1011_l",   obs_l, 32'hD);
    chk("w1011_m",   obs_m, 32'hB);
    chk("w1011_ws",  ws_l,  32'h8);
    chk("w1011_n",   obs_n, 32'd4);
    chk("w1011_cnt", bus_l.word_count, 8'd1);

    clr_obs();
    send_word(4'b1000);
    dv = 1'b0;
    drain();
    chk("w1000_m", obs_m, 32'h8);
    chk("w1000_l", obs_l, 32'h1);

    clr_obs();
    send_word(4'hA);
    send_word(4'h5);
    send_word(4'hF);
    dv = 1'b0;
    drain();
    chk("b2b_l",    obs_l,  32'h5AF);
    chk("b2b_m",    obs_m,  32'hA5F);
    chk("b2b_ws",   ws_l,   32'h888);
    chk("b2b_n",    obs_n,  32'd12);
    chk("b2b_runs", runs_l, 32'd1);

    send_word(4'hC);
    dv = 1'b0;
    tick();
    tick();
    mid_reset();
    clr_obs();
    send_word(4'h3);
    dv = 1'b0;
    drain();
    chk("rst3_l",   obs_l, 32'hC);
    chk("rst3_m",   obs_m, 32'h3);
    chk("rst3_runs", runs_l, 32'd1);
    chk("rst3_cnt", bus_l.word_count, 8'd1);

    for (int i = 0; i < 400; i++) begin
      dv  = 1'($urandom_range(0, 1));
      din = W'($urandom);
      tick();
    end
    dv = 1'b0;
    drain();

    mid_reset();
    n = 0;
    dv = 1'b1;
    for (int i = 0; i < 2000 && n < 256; i++) begin
      din = W'($urandom);
      tick();
      if (last_acc) n++;
      if (n == 256) dv = 1'b0;
    end
    dv = 1'b0;
    if (n != 256) chk("wrap_timeout", n, 32'd256);
    drain();
    chk("wrap256", bus_l.word_count, 8'd0);
    send_word(W'($urandom));
    dv = 1'b0;
    drain();
    chk("wrap257", bus_l.word_count, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
